// File: rtl/boot_rom_pkg.sv
// Shared types and limits for the multi-port boot ROM controller.
// The default byte-address width comes from `ROM_ADDR_WIDTH when the SoC
// build provides it. Otherwise it falls back to a 4 KiB ROM.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

package boot_rom_pkg;

  localparam int MAX_PORTS      = 8;
  localparam int MAX_RD_LATENCY = 4;
  localparam int PORT_ID_WIDTH  = $clog2(MAX_PORTS);
  localparam int WADDR_WIDTH    = `ROM_ADDR_WIDTH - 2;
  localparam int WORD_WIDTH     = 32;

  // One override entry: when vld is set, reads of word waddr return data.
  typedef struct packed {
    logic                   vld;
    logic [WADDR_WIDTH-1:0] waddr;
    logic [WORD_WIDTH-1:0]  data;
  } patch_entry_t;

  // Per-read tracking tag that travels alongside the ROM output.
  // hit means "data is authoritative". That holds for a patch hit at
  // stage 0 and for every read once the ROM word has been merged in.
  typedef struct packed {
    logic                     vld;
    logic [PORT_ID_WIDTH-1:0] port;
    logic                     err;
    logic                     hit;
    logic [WORD_WIDTH-1:0]    data;
  } rd_tag_t;

  // Round-robin successor of port k among n ports
  function automatic logic [PORT_ID_WIDTH-1:0] next_port(
    input logic [PORT_ID_WIDTH-1:0] k,
    input int                       n
  );
    return PORT_ID_WIDTH'((int'(k) + 1) % n);
  endfunction

endpackage

// File: rtl/boot_code.sv
// Behavioural stand-in for the boot_code ROM macro. It has a synchronous read
// with a 1-cycle latency and active-low chip select. The contents are a fixed
// hash of the word index, so every word is distinct and predictable.
module boot_code #(
  parameter int A_WIDTH = 10,
  parameter int Q_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CSN,
  input  logic [A_WIDTH-1:0] A,
  output logic [Q_WIDTH-1:0] Q
);

  logic [Q_WIDTH-1:0] q_q, q_d;

  // Look up the addressed word only when selected. Otherwise hold the output.
  always_comb begin
    q_d = q_q;
    if (!CSN) begin
      q_d = Q_WIDTH'((32'(A) * 32'h9E37_79B1) ^ 32'hB007_C0DE);
    end
  end

  // Output data register
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/boot_rom_rr_arb.sv
// Round-robin arbiter: one-hot grant from the request vector, searched
// starting at the priority pointer. The pointer moves past each winner.
module boot_rom_rr_arb
  import boot_rom_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PORTS-1:0]     req_i,
  output logic [NUM_PORTS-1:0]     gnt_o,
  output logic                     gnt_vld_o,
  output logic [PORT_ID_WIDTH-1:0] gnt_idx_o
);

  logic [PORT_ID_WIDTH-1:0] rr_q, rr_d;
  int                       cand;

  // Pick the first requester at or after rr_q. Nothing is granted while in reset.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    rr_d      = rr_q;
    cand      = 0;
    if (rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand = (int'(rr_q) + i) % NUM_PORTS;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (j == cand && req_i[j] && !gnt_vld_o) begin
            gnt_vld_o = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = PORT_ID_WIDTH'(j);
          end
        end
      end
      if (gnt_vld_o) begin
        rr_d = next_port(gnt_idx_o, NUM_PORTS);
      end
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/boot_rom_mp_ctrl.sv
// Multi-port boot ROM controller. NUM_PORTS masters are arbitrated
// round-robin onto one boot_code instance. Responses come back after
// RD_LATENCY cycles, routed to the requesting port.
// Optional feature: define BOOT_ROM_PATCH_EN to build the word-override
// patch table. Without it the patch_* inputs are ignored.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

module boot_rom_mp_ctrl
  import boot_rom_pkg::*;
#(
  parameter int ADDR_WIDTH    = `ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_PORTS     = 2,
  parameter int RD_LATENCY    = 1,
  parameter int PATCH_ENTRIES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]                  err_o,
  input  logic                                  patch_we_i,
  input  logic [$clog2(PATCH_ENTRIES)-1:0]      patch_idx_i,
  input  logic [ADDR_WIDTH-3:0]                 patch_addr_i,
  input  logic [DATA_WIDTH-1:0]                 patch_data_i,
  input  logic                                  patch_vld_i
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int DEPTH = (RD_LATENCY < 1) ? 1 :
                         (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  logic                     gnt_vld;
  logic [PORT_ID_WIDTH-1:0] gnt_idx;
  logic [ADDR_WIDTH-1:0]    gnt_addr;
  logic [WA-1:0]            gnt_waddr;
  logic                     gnt_misaligned;
  logic                     rom_csn;
  logic [DATA_WIDTH-1:0]    rom_q;
  logic                     patch_hit;
  logic [DATA_WIDTH-1:0]    patch_data;

  boot_rom_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // Select the byte address of the granted port
  always_comb begin
    gnt_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) begin
        gnt_addr = addr_i[p];
      end
    end
  end

  assign gnt_waddr      = gnt_addr[ADDR_WIDTH-1:2];
  assign gnt_misaligned = (gnt_addr[1:0] != 2'b00);
  assign rom_csn        = !(gnt_vld && !gnt_misaligned);

  boot_code #(
    .A_WIDTH (WA),
    .Q_WIDTH (DATA_WIDTH)
  ) u_rom (
    .CLK  (clk),
    .RSTN (rst_n),
    .CSN  (rom_csn),
    .A    (gnt_waddr),
    .Q    (rom_q)
  );

`ifdef BOOT_ROM_PATCH_EN
  patch_entry_t patch_q [PATCH_ENTRIES];
  patch_entry_t patch_d [PATCH_ENTRIES];

  // A table write lands at the clock edge, so a grant in the same cycle still sees the old contents
  always_comb begin
    for (int e = 0; e < PATCH_ENTRIES; e++) begin
      patch_d[e] = patch_q[e];
      if (patch_we_i && (patch_idx_i == $clog2(PATCH_ENTRIES)'(e))) begin
        patch_d[e] = '{vld: patch_vld_i, waddr: WADDR_WIDTH'(patch_addr_i),
                       data: WORD_WIDTH'(patch_data_i)};
      end
    end
  end

  // Match the granted word against the table. The downward scan lets the lowest index win.
  always_comb begin
    patch_hit  = 1'b0;
    patch_data = '0;
    for (int e = PATCH_ENTRIES - 1; e >= 0; e--) begin
      if (patch_q[e].vld && (patch_q[e].waddr == WADDR_WIDTH'(gnt_waddr))) begin
        patch_hit  = 1'b1;
        patch_data = DATA_WIDTH'(patch_q[e].data);
      end
    end
  end

  // Patch table storage, emptied by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < PATCH_ENTRIES; e++) begin
        patch_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < PATCH_ENTRIES; e++) begin
        patch_q[e] <= patch_d[e];
      end
    end
  end
`else
  logic unused_patch;
  assign unused_patch = ^{patch_we_i, patch_idx_i, patch_addr_i, patch_data_i, patch_vld_i};
  assign patch_hit    = 1'b0;
  assign patch_data   = '0;
`endif

  rd_tag_t               stage_q [DEPTH];
  rd_tag_t               stage_d [DEPTH];
  rd_tag_t               out_tag;
  logic [DATA_WIDTH-1:0] out_data;

  // Final word for a tag: zero on error, the carried data if authoritative, else the ROM output
  function automatic logic [DATA_WIDTH-1:0] resolve(input rd_tag_t t,
                                                    input logic [DATA_WIDTH-1:0] rom);
    if (t.err) return '0;
    if (t.hit) return DATA_WIDTH'(t.data);
    return rom;
  endfunction

  // Load stage 0 at grant. The ROM word is merged into the tag while leaving stage 0.
  always_comb begin
    stage_d[0] = '{vld: gnt_vld, port: gnt_idx, err: gnt_misaligned,
                   hit: patch_hit, data: WORD_WIDTH'(patch_data)};
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
      if (s == 1) begin
        stage_d[s].hit  = 1'b1;
        stage_d[s].data = WORD_WIDTH'(resolve(stage_q[0], rom_q));
      end
    end
  end

  // Tracking pipeline. Reset discards every in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign out_tag  = stage_q[DEPTH-1];
  assign out_data = resolve(out_tag, rom_q);

  // Route the response to the tagged port only. Every other lane stays zero.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_tag.vld && (out_tag.port == PORT_ID_WIDTH'(p))) begin
        rvalid_o[p] = 1'b1;
        rdata_o[p]  = out_data;
        err_o[p]    = out_tag.err;
      end
    end
  end

endmodule

// File: tb/tb_boot_rom_mp_ctrl.sv
// Bench for boot_rom_mp_ctrl. Four copies with RD_LATENCY 1..4 share one
// stimulus stream. Each copy has its own queue of expected responses.
// The patch scenarios are modelled only when BOOT_ROM_PATCH_EN is defined.
`timescale 1ns/1ps

module tb_boot_rom_mp_ctrl;

  localparam int NP   = 2;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int NLAT = 4;
  localparam int PE   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          req;
  logic [NP-1:0][AW-1:0]  addr;
  logic                   pwe;
  logic [1:0]             pidx;
  logic [AW-3:0]          paddr;
  logic [DW-1:0]          pdata;
  logic                   pvld;

  logic [NP-1:0]         gnt_w    [NLAT];
  logic [NP-1:0]         rvalid_w [NLAT];
  logic [NP-1:0]         err_w    [NLAT];
  logic [NP-1:0][DW-1:0] rdata_w  [NLAT];

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q [NLAT][$];

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;

  // Reference state: priority pointer and patch table
  int          model_rr = 0;
  logic        pm_vld  [PE];
  int          pm_addr [PE];
  logic [31:0] pm_data [PE];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NLAT; g++) begin : g_dut
    boot_rom_mp_ctrl #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .NUM_PORTS     (NP),
      .RD_LATENCY    (g + 1),
      .PATCH_ENTRIES (PE)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .addr_i       (addr),
      .gnt_o        (gnt_w[g]),
      .rvalid_o     (rvalid_w[g]),
      .rdata_o      (rdata_w[g]),
      .err_o        (err_w[g]),
      .patch_we_i   (pwe),
      .patch_idx_i  (pidx),
      .patch_addr_i (paddr),
      .patch_data_i (pdata),
      .patch_vld_i  (pvld)
    );
  end

  // ROM image of the boot_code macro
  function automatic logic [31:0] rom_model(input int w);
    logic [31:0] x;
    x = 32'(w);
    return (x * 32'h9E37_79B1) ^ 32'hB007_C0DE;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the grant, and record the expected responses
  task automatic applyStimulus(input logic rst_v, input logic [NP-1:0] r,
                               input int a0, input int a1,
                               input logic we, input int idx, input int pa,
                               input logic [31:0] pd, input logic pv);
    logic [NP-1:0] exp_g;
    int            gk;
    int            a;
    int            word;
    logic          e;
    logic [31:0]   d;
    int            hit;
    @(posedge clk);
    #1;
    rst_n   = rst_v;
    req     = r;
    addr[0] = AW'(a0);
    addr[1] = AW'(a1);
    pwe     = we;
    pidx    = 2'(idx);
    paddr   = (AW-2)'(pa);
    pdata   = pd;
    pvld    = pv;
    #1;
    exp_g = '0;
    gk    = -1;
    if (rst_v) begin
      for (int i = 0; i < NP; i++) begin
        if (gk < 0 && r[(model_rr + i) % NP]) gk = (model_rr + i) % NP;
      end
    end
    if (gk >= 0) exp_g[gk] = 1'b1;
    for (int l = 0; l < NLAT; l++) begin
      checkOutput($sformatf("gnt L%0d", l + 1), 64'(gnt_w[l]), 64'(exp_g));
    end
    if (!rst_v) begin
      for (int l = 0; l < NLAT; l++) begin
        while (exp_q[l].size() > 0 && exp_q[l][$].due >= cyc + 1) void'(exp_q[l].pop_back());
      end
      model_rr = 0;
      for (int i = 0; i < PE; i++) pm_vld[i] = 1'b0;
    end else begin
      if (gk >= 0) begin
        a    = (gk == 0) ? a0 : a1;
        word = (a % (1 << AW)) / 4;
        e    = (a % 4) != 0;
        hit  = -1;
`ifdef BOOT_ROM_PATCH_EN
        for (int i = 0; i < PE; i++) begin
          if (hit < 0 && pm_vld[i] && pm_addr[i] == word) hit = i;
        end
`endif
        d = e ? 32'h0 : (hit >= 0) ? pm_data[hit] : rom_model(word);
        for (int l = 0; l < NLAT; l++) exp_q[l].push_back('{cyc + l + 1, gk, d, e});
        model_rr = (gk + 1) % NP;
      end
`ifdef BOOT_ROM_PATCH_EN
      if (we) begin
        pm_vld[idx]  = pv;
        pm_addr[idx] = pa;
        pm_data[idx] = pd;
      end
`endif
    end
  endtask

  task automatic rd(input logic [NP-1:0] r, input int a0, input int a1);
    applyStimulus(1'b1, r, a0, a1, 1'b0, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic pw(input int idx, input int pa, input logic [31:0] pd, input logic pv);
    applyStimulus(1'b1, '0, 0, 0, 1'b1, idx, pa, pd, pv);
  endtask

  // Per-latency monitor: pop the response due this cycle and compare every output lane
  for (genvar g = 0; g < NLAT; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t                  e;
      logic [NP-1:0]         ev;
      logic [NP-1:0]         ee;
      logic [NP-1:0][DW-1:0] ed;
      if (mon_en) begin
        ev = '0;
        ee = '0;
        ed = '0;
        while (exp_q[g].size() > 0 && exp_q[g][0].due < cyc) begin
          e = exp_q[g].pop_front();
          checkOutput($sformatf("late rsp L%0d", g + 1), 64'(e.due), 64'(cyc));
        end
        if (exp_q[g].size() > 0 && exp_q[g][0].due == cyc) begin
          e = exp_q[g].pop_front();
          ev[e.port] = 1'b1;
          ee[e.port] = e.err;
          ed[e.port] = e.data;
        end
        checkOutput($sformatf("rvalid L%0d", g + 1), 64'(rvalid_w[g]), 64'(ev));
        checkOutput($sformatf("err L%0d", g + 1), 64'(err_w[g]), 64'(ee));
        checkOutput($sformatf("rdata L%0d", g + 1), 64'(rdata_w[g]), 64'(ed));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rq, w, a0, a1;
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    pwe   = 1'b0;
    pidx  = '0;
    paddr = '0;
    pdata = '0;
    pvld  = 1'b0;
    for (int i = 0; i < PE; i++) begin
      pm_vld[i]  = 1'b0;
      pm_addr[i] = 0;
      pm_data[i] = '0;
    end

    $display("[TB] reset with requests pending");
    applyStimulus(1'b0, 2'b11, 0, 4, 1'b0, 0, 0, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b11, 0, 4, 1'b0, 0, 0, 32'h0, 1'b0);
    mon_en = 1'b1;
    applyStimulus(1'b0, 2'b00, 0, 0, 1'b0, 0, 0, 32'h0, 1'b0);
    rd(2'b00, 0, 0);

    $display("[TB] directed reads");
    rd(2'b01, 32'h0, 0);
    rd(2'b01, 32'h4, 0);
    rd(2'b10, 0, 32'h8);
    for (int i = 0; i < 4; i++) rd(2'b11, 32'h10 + 4 * i, 32'h100 + 4 * i);
    rd(2'b01, 32'h6, 0);
    rd(2'b00, 0, 0);

    $display("[TB] patch table");
    pw(1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    rd(2'b01, 32'h40, 0);
    pw(1, 32'h10, 32'h0, 1'b0);
    rd(2'b01, 32'h40, 0);
    pw(2, 32'h11, 32'h1234_5678, 1'b1);
    pw(0, 32'h11, 32'hCAFE_F00D, 1'b1);
    rd(2'b10, 0, 32'h44);
    applyStimulus(1'b1, 2'b01, 32'h44, 0, 1'b1, 0, 32'h11, 32'h0, 1'b0);
    rd(2'b01, 32'h44, 0);

    $display("[TB] reset during a read");
    rd(2'b01, 32'h20, 0);
    applyStimulus(1'b0, 2'b00, 0, 0, 1'b0, 0, 0, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 0, 0, 1'b0, 0, 0, 32'h0, 1'b0);
    rd(2'b11, 32'h24, 32'h28);
    rd(2'b11, 32'h2C, 32'h30);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rq = $urandom_range(0, 3);
      w  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
      a0 = w * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      w  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
      a1 = w * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 63) == 0) begin
        applyStimulus(1'b0, NP'(rq), a0, a1, 1'b0, 0, 0, 32'h0, 1'b0);
      end else begin
        applyStimulus(1'b1, NP'(rq), a0, a1, ($urandom_range(0, 5) == 0),
                      $urandom_range(0, PE - 1), $urandom_range(0, 15), $urandom,
                      ($urandom_range(0, 3) != 0));
      end
    end

    for (int i = 0; i < 6; i++) rd(2'b00, 0, 0);
    @(posedge clk);
    #2;
    for (int l = 0; l < NLAT; l++) begin
      checkOutput($sformatf("drained L%0d", l + 1), 64'(exp_q[l].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
